// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port 256x8 RAM.
// The RAM has a registered read with 1-cycle latency and is read-before-write.
// Round-robin arbitration with an optional burst lock. Read data returns
// one cycle after the grant, together with a valid pulse for the issuer.
// Build option: define RAM_ARB_FIXED_PRI_EN for fixed priority (A always
// wins a tie). In that mode the lock inputs are ignored and burst_cnt stays 0.
module ram_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_write_enable,
  input  logic [DW-1:0] ram_data_out
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  logic       last_gnt;   // 0 = A won last, 1 = B won last
  logic [3:0] burst_cnt;
  logic       rd_pend_a;
  logic       rd_pend_b;
  logic       grant;
  logic       sel_b;

`ifdef RAM_ARB_FIXED_PRI_EN
  logic unused_lock;
  assign unused_lock = a_lock ^ b_lock;
`else
  logic win_lock;
  assign win_lock = sel_b ? b_lock : a_lock;
`endif

  // Winner selection; with no grant the mux keeps pointing at the last winner
  always_comb begin
    grant = 1'b0;
    sel_b = last_gnt;
    if (!rst) begin
      if (a_req && b_req) begin
        grant = 1'b1;
`ifdef RAM_ARB_FIXED_PRI_EN
        sel_b = 1'b0;
`else
        if (!last_gnt && a_lock && (burst_cnt < MAX_BURST_C))
          sel_b = 1'b0;
        else if (last_gnt && b_lock && (burst_cnt < MAX_BURST_C))
          sel_b = 1'b1;
        else
          sel_b = ~last_gnt;
`endif
      end else if (a_req) begin
        grant = 1'b1;
        sel_b = 1'b0;
      end else if (b_req) begin
        grant = 1'b1;
        sel_b = 1'b1;
      end
    end
  end

  assign a_gnt            = grant & ~sel_b;
  assign b_gnt            = grant &  sel_b;
  assign ram_address      = sel_b ? b_addr  : a_addr;
  assign ram_data_in      = sel_b ? b_wdata : a_wdata;
  assign ram_write_enable = grant & (sel_b ? b_we : a_we);

  assign a_rdata  = ram_data_out;
  assign b_rdata  = ram_data_out;
  assign a_rvalid = rd_pend_a;
  assign b_rvalid = rd_pend_b;

  // Priority history, burst length and read-return tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt  <= 1'b1;
      burst_cnt <= '0;
      rd_pend_a <= 1'b0;
      rd_pend_b <= 1'b0;
    end else begin
      rd_pend_a <= a_gnt & ~a_we;
      rd_pend_b <= b_gnt & ~b_we;
      if (grant) begin
        last_gnt <= sel_b;
`ifndef RAM_ARB_FIXED_PRI_EN
        if ((sel_b == last_gnt) && win_lock)
          burst_cnt <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
        else
          burst_cnt <= win_lock ? 4'd1 : 4'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM model.
module tb_ram_arbiter;

  logic       clk;
  logic       rst;
  logic       a_req, a_we, a_lock;
  logic [7:0] a_addr, a_wdata;
  logic       a_gnt, a_rvalid;
  logic [7:0] a_rdata;
  logic       b_req, b_we, b_lock;
  logic [7:0] b_addr, b_wdata;
  logic       b_gnt, b_rvalid;
  logic [7:0] b_rdata;
  logic [7:0] ram_address, ram_data_in, ram_data_out;
  logic       ram_write_enable;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );

  // Single-port RAM: registered read, read-before-write
  logic [7:0] mem [256];
  always @(posedge clk) begin
    ram_data_out <= mem[ram_address];
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    cyc(); idle(); rst = 1;
    cyc(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    cyc(); cyc();
    a_req = 1; a_we = 1; b_req = 1; b_we = 1;
    #1;
    checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL reset_a_gnt: got %b want 0", a_gnt); end
    checks++; if (b_gnt !== 1'b0) begin errors++; $display("FAIL reset_b_gnt: got %b want 0", b_gnt); end
    checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", ram_write_enable); end
    cyc();
    checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b want 00", a_rvalid, b_rvalid); end
    idle(); rst = 0;
  endtask

  task automatic test_write_read_a();
    cyc(); a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h5A; #1;
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL wr_a_gnt: got %b want 1", a_gnt); end
    checks++; if (b_gnt !== 1'b0) begin errors++; $display("FAIL wr_b_gnt: got %b want 0", b_gnt); end
    checks++; if (ram_write_enable !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", ram_write_enable); end
    checks++; if (ram_address !== 8'h10) begin errors++; $display("FAIL wr_addr: got %h want 10", ram_address); end
    checks++; if (ram_data_in !== 8'h5A) begin errors++; $display("FAIL wr_data: got %h want 5a", ram_data_in); end
    cyc(); a_we = 0; #1;
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL rd_a_gnt: got %b want 1", a_gnt); end
    checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL rd_we: got %b want 0", ram_write_enable); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %b want 0", a_rvalid); end
    cyc(); idle(); #1;
    checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL rd_a_rvalid: got %b want 1", a_rvalid); end
    checks++; if (a_rdata !== 8'h5A) begin errors++; $display("FAIL rd_a_rdata: got %h want 5a", a_rdata); end
    checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL rd_b_rvalid: got %b want 0", b_rvalid); end
    checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || ram_write_enable !== 1'b0) begin
      errors++; $display("FAIL idle: got gnt %b%b we %b want 000", a_gnt, b_gnt, ram_write_enable); end
    cyc(); #1;
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse_len: got %b want 0", a_rvalid); end
  endtask

  task automatic test_write_read_b();
    cyc(); b_req = 1; b_we = 1; b_addr = 8'h20; b_wdata = 8'h33; #1;
    checks++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin errors++; $display("FAIL wrb_gnt: got a%b b%b want a0 b1", a_gnt, b_gnt); end
    checks++; if (ram_address !== 8'h20 || ram_data_in !== 8'h33 || ram_write_enable !== 1'b1) begin
      errors++; $display("FAIL wrb_bus: got %h %h %b want 20 33 1", ram_address, ram_data_in, ram_write_enable); end
    cyc(); b_we = 0; #1;
    cyc(); idle(); #1;
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 8'h33) begin errors++; $display("FAIL rdb: got v%b d%h want v1 d33", b_rvalid, b_rdata); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rdb_a_rvalid: got %b want 0", a_rvalid); end
    // seed read-back locations for the arbitration tests
    cyc(); a_req = 1; a_we = 1; a_addr = 8'h01; a_wdata = 8'h11;
    cyc(); idle(); b_req = 1; b_we = 1; b_addr = 8'h02; b_wdata = 8'h22;
    cyc(); idle();
  endtask

  task automatic test_round_robin();
    logic pa, pb, ea;
    do_reset();
    pa = 0; pb = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      a_req = 1; a_addr = 8'h01; b_req = 1; b_addr = 8'h02;
      #1;
`ifdef RAM_ARB_FIXED_PRI_EN
      ea = 1'b1;
`else
      ea = (i % 2 == 0);
`endif
      checks++; if (a_gnt !== ea || b_gnt !== ~ea) begin
        errors++; $display("FAIL rr_gnt[%0d]: got a%b b%b want a%b b%b", i, a_gnt, b_gnt, ea, ~ea); end
      checks++; if (ram_address !== (ea ? 8'h01 : 8'h02)) begin
        errors++; $display("FAIL rr_addr[%0d]: got %h want %h", i, ram_address, ea ? 8'h01 : 8'h02); end
      checks++; if (a_rvalid !== pa || b_rvalid !== pb) begin
        errors++; $display("FAIL rr_rvalid[%0d]: got a%b b%b want a%b b%b", i, a_rvalid, b_rvalid, pa, pb); end
      if (pa) begin checks++; if (a_rdata !== 8'h11) begin errors++; $display("FAIL rr_a_rdata[%0d]: got %h want 11", i, a_rdata); end end
      if (pb) begin checks++; if (b_rdata !== 8'h22) begin errors++; $display("FAIL rr_b_rdata[%0d]: got %h want 22", i, b_rdata); end end
      pa = ea; pb = ~ea;
    end
    cyc(); idle(); #1;
    checks++; if (a_rvalid !== pa || b_rvalid !== pb) begin
      errors++; $display("FAIL rr_rvalid_last: got a%b b%b want a%b b%b", a_rvalid, b_rvalid, pa, pb); end
  endtask

`ifndef RAM_ARB_FIXED_PRI_EN
  task automatic test_burst_lock();
    logic [6:0] exp_a;
    exp_a = 7'b1101111;  // bit i = A expected to win in cycle i
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc();
      a_req = 1; a_lock = 1; a_addr = 8'h01; b_req = 1; b_addr = 8'h02;
      #1;
      checks++; if (a_gnt !== exp_a[i] || b_gnt !== ~exp_a[i]) begin
        errors++; $display("FAIL burst_gnt[%0d]: got a%b b%b want a%b b%b", i, a_gnt, b_gnt, exp_a[i], ~exp_a[i]); end
    end
    cyc(); idle();
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    cyc(); a_req = 1; a_we = 1; a_addr = 8'h40; a_wdata = 8'h77;   // A wins, becomes last winner
    cyc(); a_we = 0; #1;
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b want 1", a_gnt); end
    #1; rst = 1; #1;
    checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL rm_gnt_in_rst: got %b want 0", a_gnt); end
    cyc(); idle(); #1;
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid1: got %b want 0", a_rvalid); end
    rst = 0;
    cyc(); #1;
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid2: got %b want 0", a_rvalid); end
    a_req = 1; b_req = 1; #1;
    checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL rm_pri: got a%b b%b want a1 b0", a_gnt, b_gnt); end
    cyc(); idle();
  endtask

`ifdef RAM_ARB_FIXED_PRI_EN
  task automatic test_fixed_pri();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(); a_req = 1; b_req = 1; #1;
      checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
        errors++; $display("FAIL fixed_gnt[%0d]: got a%b b%b want a1 b0", i, a_gnt, b_gnt); end
    end
    cyc(); idle();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read_a();
    test_write_read_b();
    test_round_robin();
`ifndef RAM_ARB_FIXED_PRI_EN
    test_burst_lock();
`endif
    test_reset_mid();
`ifdef RAM_ARB_FIXED_PRI_EN
    test_fixed_pri();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
